// File: rtl/switch_debounce_pkg.sv
// Shared types and 25 MHz default timing constants for the push-button conditioning path.
package switch_debounce_pkg;

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_HELD         = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } sw_state_t;

    localparam int DEF_DEBOUNCE_CYCLES   = 250000;    // 10 ms at 25 MHz
    localparam int DEF_SYNC_STAGES       = 2;
    localparam int DEF_LONG_PRESS_CYCLES = 25000000;  // 1 s at 25 MHz

endpackage

// File: rtl/sw_sync.sv
// Multi-flop synchronizer for a slow asynchronous level; reusable for any board switch.
// Latency STAGES cycles; no backpressure.
module sw_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic sync_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
        end
    end

    assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/switch_debounce.sv
// Synchronises and debounces the push button into a clean level plus press/release pulses.
// Press/release latency SYNC_STAGES + DEBOUNCE_CYCLES; optional long-press pulse under SW_LONG_PRESS_EN.
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_SW,
    output logic o_sw_level,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_long_press
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (DEBOUNCE_CYCLES < 2 || SYNC_STAGES < 2 || LONG_PRESS_CYCLES < 1) begin : g_bad_param
        $error("switch_debounce: illegal parameter value");
    end

    logic             sw_s;
    sw_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    sw_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (i_clk),
        .rst_n_i (i_rst_n),
        .async_i (i_SW),
        .sync_o  (sw_s)
    );

    // cnt holds the number of consecutive confirming samples seen in a *_WAIT state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                level_d = 1'b0;
                cnt_d   = '0;
                if (sw_s) begin
                    state_d = S_PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            S_PRESS_WAIT: begin
                if (!sw_s) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HELD;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HELD: begin
                level_d = 1'b1;
                cnt_d   = '0;
                if (!sw_s) begin
                    state_d = S_RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            S_RELEASE_WAIT: begin
                if (sw_s) begin
                    state_d = S_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign o_sw_level      = level_q;
    assign o_press_pulse   = press_q;
    assign o_release_pulse = release_q;

`ifdef SW_LONG_PRESS_EN
    localparam int                HOLD_W    = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;

    // Release-wait cycles keep counting so a short bounce neither resets nor delays the hold
    always_comb begin
        hold_d = '0;
        if ((state_q == S_HELD || state_q == S_RELEASE_WAIT) && state_d != S_IDLE) begin
            hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + HOLD_ONE;
        end
        long_d = (hold_d == HOLD_LAST) && (hold_q != HOLD_LAST);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign o_long_press = long_q;
`else
    assign o_long_press = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with DEBOUNCE_CYCLES=8, SYNC_STAGES=2, LONG_PRESS_CYCLES=32.
module tb_switch_debounce;
    import switch_debounce_pkg::*;

    logic i_clk;
    logic i_rst_n;
    logic i_SW;
    logic o_sw_level;
    logic o_press_pulse;
    logic o_release_pulse;
    logic o_long_press;

    switch_debounce #(
        .DEBOUNCE_CYCLES   (8),
        .SYNC_STAGES       (2),
        .LONG_PRESS_CYCLES (32)
    ) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_SW            (i_SW),
        .o_sw_level      (o_sw_level),
        .o_press_pulse   (o_press_pulse),
        .o_release_pulse (o_release_pulse),
        .o_long_press    (o_long_press)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    int   cyc;
    int   press_n, press_at, rel_n, rel_at, long_n, long_at;
    int   rise_at, fall_at;
    int   both_n = 0;
    logic lvl_prev = 1'b0;

    task automatic clr();
        cyc      = 0;
        press_n  = 0;
        press_at = -1;
        rel_n    = 0;
        rel_at   = -1;
        long_n   = 0;
        long_at  = -1;
        rise_at  = -1;
        fall_at  = -1;
    endtask

    // Advance one edge, then sample outputs 1 time unit later; cycle k = after the k-th edge.
    task automatic step();
        @(posedge i_clk);
        #1;
        cyc++;
        if (o_press_pulse) begin
            press_n++;
            if (press_at < 0) press_at = cyc;
        end
        if (o_release_pulse) begin
            rel_n++;
            if (rel_at < 0) rel_at = cyc;
        end
        if (o_long_press) begin
            long_n++;
            if (long_at < 0) long_at = cyc;
        end
        if (o_press_pulse && o_release_pulse) both_n++;
        if (o_sw_level && !lvl_prev && rise_at < 0) rise_at = cyc;
        if (!o_sw_level && lvl_prev && fall_at < 0) fall_at = cyc;
        lvl_prev = o_sw_level;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_SW    = 1'b0;
        clr();
        run(3);
        chk("rst_level", int'(o_sw_level), 0);
        chk("rst_press", int'(o_press_pulse), 0);
        chk("rst_release", int'(o_release_pulse), 0);
        chk("rst_long", int'(o_long_press), 0);
        chk("rst_state", int'(dut.state_q), int'(S_IDLE));

        // Idle with switch released
        i_rst_n = 1'b1;
        clr();
        run(50);
        chk("idle_press_n", press_n, 0);
        chk("idle_rel_n", rel_n, 0);
        chk("idle_level", int'(o_sw_level), 0);
        chk("idle_state", int'(dut.state_q), int'(S_IDLE));

        // Clean press: pulse and level rise at cycle 2 + 8
        i_SW = 1'b1;
        clr();
        run(20);
        chk("press_n", press_n, 1);
        chk("press_at", press_at, 10);
        chk("press_level_rise", rise_at, 10);
        chk("press_no_release", rel_n, 0);

        // Clean release
        i_SW = 1'b0;
        clr();
        run(20);
        chk("release_n", rel_n, 1);
        chk("release_at", rel_at, 10);
        chk("release_level_fall", fall_at, 10);
        chk("release_no_press", press_n, 0);

        // 7-cycle glitch is rejected
        i_SW = 1'b1;
        clr();
        run(7);
        i_SW = 1'b0;
        run(15);
        chk("glitch7_press_n", press_n, 0);
        chk("glitch7_level_rise", rise_at, -1);

        // 8-cycle pulse is accepted, release follows at minimum spacing
        i_SW = 1'b1;
        clr();
        run(8);
        i_SW = 1'b0;
        run(20);
        chk("pulse8_press_n", press_n, 1);
        chk("pulse8_press_at", press_at, 10);
        chk("pulse8_rel_n", rel_n, 1);
        chk("pulse8_rel_at", rel_at, 18);
        chk("pulse8_spacing", rel_at - press_at, 8);

        // Release bounce: 0 x5, 1 x3, then 0
        i_SW = 1'b1;
        run(20);
        clr();
        i_SW = 1'b0;
        run(5);
        i_SW = 1'b1;
        run(3);
        i_SW = 1'b0;
        run(20);
        chk("rbounce_rel_n", rel_n, 1);
        chk("rbounce_rel_at", rel_at, 18);
        chk("rbounce_press_n", press_n, 0);
        chk("rbounce_level", int'(o_sw_level), 0);

        // Reset while counting a press
        i_SW = 1'b1;
        clr();
        run(7);
        chk("midcnt_state", int'(dut.state_q), int'(S_PRESS_WAIT));
        chk("midcnt_cnt", int'(dut.cnt_q), 5);
        i_rst_n = 1'b0;
        clr();
        run(3);
        chk("midrst_press_n", press_n, 0);
        chk("midrst_level", int'(o_sw_level), 0);
        chk("midrst_state", int'(dut.state_q), int'(S_IDLE));
        i_rst_n = 1'b1;
        clr();
        run(20);
        chk("postrst_press_n", press_n, 1);
        chk("postrst_press_at", press_at, 10);
        chk("postrst_rel_n", rel_n, 0);
        i_SW = 1'b0;
        run(20);

        // Long hold with a 3-cycle release bounce partway through
        i_SW = 1'b1;
        clr();
        run(20);
        i_SW = 1'b0;
        run(3);
        i_SW = 1'b1;
        run(77);
        chk("hold_press_n", press_n, 1);
        chk("hold_press_at", press_at, 10);
        chk("hold_rel_n", rel_n, 0);
`ifdef SW_LONG_PRESS_EN
        chk("hold_long_n", long_n, 1);
        chk("hold_long_at", long_at, 42);
`else
        chk("hold_long_n", long_n, 0);
`endif
        i_SW = 1'b0;
        run(20);
        chk("hold_end_rel_n", rel_n, 1);
        chk("hold_end_long_n", long_n, `ifdef SW_LONG_PRESS_EN 1 `else 0 `endif);

        chk("no_overlap", both_n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
